// File: rtl/rolling_sequencer.sv
// Rolling four-digit display sequencer: synchronises switches and the step
// key, permutes four 4-bit digits once per step event, and drives four
// active-low seven-segment displays plus a step counter.
module rolling_sequencer #(
  parameter int          TICK_DIV    = 50000000,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] INIT_DIGITS = 16'h3210
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [3:0] SW,
  input  logic       KEY_STEP_N,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [7:0] STEP_CNT,
  output logic [1:0] STATE_OUT
);

  localparam int            PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_HOLD     = 2'd0,
    MODE_REV      = 2'd1,
    MODE_SWAP02   = 2'd2,
    MODE_PAIRSWAP = 2'd3
  } mode_t;

  logic [SYNC_STAGES-1:0][3:0] sw_sync_q, sw_sync_d;
  logic [SYNC_STAGES-1:0]      key_sync_q, key_sync_d;
  logic                        key_prev_q, key_prev_d;
  state_t                      state_q, state_d;
  mode_t                       mode_q, mode_d;
  logic [PW-1:0]               presc_q, presc_d;
  logic [15:0]                 digits_q, digits_d;
  logic [7:0]                  cnt_q, cnt_d;

  logic [3:0] sw_s;
  logic       run_en;
  logic       step_evt;
  logic       tick;
  mode_t      mode_req;

  // SW[0] beats SW[1] beats SW[2]; nothing set means the digits stay put.
  function automatic mode_t decode_mode(input logic [2:0] s);
    if (s[0])      return MODE_REV;
    else if (s[1]) return MODE_SWAP02;
    else if (s[2]) return MODE_PAIRSWAP;
    else           return MODE_HOLD;
  endfunction

  // Digit word is {d3,d2,d1,d0}.
  function automatic logic [15:0] permute(input logic [15:0] d, input mode_t m);
    case (m)
      MODE_REV:      return {d[3:0], d[7:4], d[11:8], d[15:12]};
      MODE_SWAP02:   return {d[15:12], d[3:0], d[7:4], d[11:8]};
      MODE_PAIRSWAP: return {d[11:8], d[15:12], d[3:0], d[7:4]};
      default:       return d;
    endcase
  endfunction

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  // Shift the raw inputs through the synchroniser chains and keep the last
  // synchronised key level for falling-edge detection.
  always_comb begin
    sw_sync_d  = {sw_sync_q[SYNC_STAGES-2:0], SW};
    key_sync_d = {key_sync_q[SYNC_STAGES-2:0], KEY_STEP_N};
    key_prev_d = key_sync_q[SYNC_STAGES-1];
  end

  assign sw_s     = sw_sync_q[SYNC_STAGES-1];
  assign run_en   = sw_s[3];
  assign mode_req = decode_mode(sw_s[2:0]);
  assign step_evt = key_prev_q & ~key_sync_q[SYNC_STAGES-1];
  assign tick     = (state_q == ST_RUN) && (presc_q == TICK_LAST);

  // Next-state logic: prescaler only advances in RUN, freezes in APPLY, and
  // sits at zero in IDLE so each entry into RUN starts a full period.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    presc_d  = presc_q;
    digits_d = digits_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        if (run_en) begin
          state_d = ST_RUN;
        end else if (step_evt) begin
          state_d = ST_APPLY;
          mode_d  = mode_req;
        end
      end
      ST_RUN: begin
        if (!run_en) begin
          state_d = ST_IDLE;
          presc_d = '0;
        end else if (tick) begin
          state_d = ST_APPLY;
          mode_d  = mode_req;
          presc_d = '0;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      ST_APPLY: begin
        digits_d = permute(digits_q, mode_q);
        if (mode_q != MODE_HOLD) cnt_d = cnt_q + 8'd1;
        state_d = run_en ? ST_RUN : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        presc_d = '0;
      end
    endcase
  end

  // All state registers; reset restores the initial digits immediately.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sw_sync_q  <= '0;
      key_sync_q <= '1;
      key_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      mode_q     <= MODE_HOLD;
      presc_q    <= '0;
      digits_q   <= INIT_DIGITS;
      cnt_q      <= '0;
    end else begin
      sw_sync_q  <= sw_sync_d;
      key_sync_q <= key_sync_d;
      key_prev_q <= key_prev_d;
      state_q    <= state_d;
      mode_q     <= mode_d;
      presc_q    <= presc_d;
      digits_q   <= digits_d;
      cnt_q      <= cnt_d;
    end
  end

  assign STATE_OUT = state_q;
  assign STEP_CNT  = cnt_q;
  assign HEX0      = hex7(digits_q[3:0]);
  assign HEX1      = hex7(digits_q[7:4]);
  assign HEX2      = hex7(digits_q[11:8]);
  assign HEX3      = hex7(digits_q[15:12]);

endmodule

// File: tb/tb_rolling_sequencer.sv
// Bench for rolling_sequencer: table-driven manual steps, hand-written
// auto-mode corner cases and random stimulus against a behavioural model.
module tb_rolling_sequencer;

  localparam int          TD   = 4;
  localparam int          SS   = 2;
  localparam logic [15:0] INIT = 16'h3210;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = 4'd0;
  logic       key_n = 1'b1;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic [7:0] step_cnt;
  logic [1:0] state_out;

  int n_checks = 0;
  int n_fail   = 0;

  rolling_sequencer #(
    .TICK_DIV(TD), .SYNC_STAGES(SS), .INIT_DIGITS(INIT)
  ) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .SW(sw), .KEY_STEP_N(key_n),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3),
    .STEP_CNT(step_cnt), .STATE_OUT(state_out)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [3:0] m_d [4];
  int         m_cnt;
  bit         m_run;
  bit         m_pend;
  int         m_perm;
  int         m_wait;
  logic [3:0] m_sw_hist [$];
  bit         m_key_hist [$];

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  // 0 = hold, 1 = reverse, 2 = swap d0/d2, 3 = swap pairs
  function automatic int decode_mode(input logic [3:0] s);
    if (s[0]) return 1;
    if (s[1]) return 2;
    if (s[2]) return 3;
    return 0;
  endfunction

  // Index of the old digit that lands in position i.
  function automatic int src_of(input int perm, input int i);
    case (perm)
      1:       return 3 - i;
      2:       return (i == 0) ? 2 : (i == 2) ? 0 : i;
      3:       return i ^ 1;
      default: return i;
    endcase
  endfunction

  task automatic model_reset();
    logic [15:0] init_v;
    init_v = INIT;
    for (int i = 0; i < 4; i++) m_d[i] = init_v[4*i +: 4];
    m_cnt  = 0;
    m_run  = 0;
    m_pend = 0;
    m_perm = 0;
    m_wait = 0;
    m_sw_hist.delete();
    m_key_hist.delete();
    for (int i = 0; i <= SS; i++) begin
      m_sw_hist.push_back(4'd0);
      m_key_hist.push_back(1'b1);
    end
  endtask

  // One rising edge: act on what the design saw during the preceding cycle,
  // then record the raw inputs captured at this edge.
  task automatic model_edge(input logic [3:0] s_in, input logic k_in);
    logic [3:0] s_sync;
    bit         evt;
    logic [3:0] old [4];
    s_sync = m_sw_hist[SS-1];
    evt    = m_key_hist[SS] && !m_key_hist[SS-1];
    if (m_pend) begin
      for (int i = 0; i < 4; i++) old[i] = m_d[i];
      for (int i = 0; i < 4; i++) m_d[i] = old[src_of(m_perm, i)];
      if (m_perm != 0) m_cnt = (m_cnt + 1) % 256;
      m_pend = 0;
      m_run  = s_sync[3];
      m_wait = 0;
    end else if (m_run) begin
      if (!s_sync[3]) begin
        m_run  = 0;
        m_wait = 0;
      end else if (m_wait == TD - 1) begin
        m_pend = 1;
        m_perm = decode_mode(s_sync);
        m_wait = 0;
      end else begin
        m_wait++;
      end
    end else begin
      if (s_sync[3]) begin
        m_run  = 1;
        m_wait = 0;
      end else if (evt) begin
        m_pend = 1;
        m_perm = decode_mode(s_sync);
      end
    end
    m_sw_hist.push_front(s_in);
    void'(m_sw_hist.pop_back());
    m_key_hist.push_front(k_in);
    void'(m_key_hist.pop_back());
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  task automatic check_model();
    int st;
    st = m_pend ? 2 : (m_run ? 1 : 0);
    check("model_hex0", {25'd0, hex0}, {25'd0, glyph(m_d[0])});
    check("model_hex1", {25'd0, hex1}, {25'd0, glyph(m_d[1])});
    check("model_hex2", {25'd0, hex2}, {25'd0, glyph(m_d[2])});
    check("model_hex3", {25'd0, hex3}, {25'd0, glyph(m_d[3])});
    check("model_cnt", {24'd0, step_cnt}, m_cnt);
    check("model_state", {30'd0, state_out}, st);
  endtask

  task automatic check_digits(input string name, input logic [15:0] w);
    check({name, "_hex0"}, {25'd0, hex0}, {25'd0, glyph(w[3:0])});
    check({name, "_hex1"}, {25'd0, hex1}, {25'd0, glyph(w[7:4])});
    check({name, "_hex2"}, {25'd0, hex2}, {25'd0, glyph(w[11:8])});
    check({name, "_hex3"}, {25'd0, hex3}, {25'd0, glyph(w[15:12])});
  endtask

  // Drive inputs at the falling edge, advance one clock, check at the next falling edge.
  task automatic cycle(input logic [3:0] s, input logic k);
    sw    = s;
    key_n = k;
    @(posedge clk);
    model_edge(s, k);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    sw    = 4'd0;
    key_n = 1'b1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_apply(input logic [3:0] s, input string name);
    int c;
    c = 0;
    while (state_out != 2'd2 && c < 40) begin
      cycle(s, 1'b1);
      c++;
    end
    if (state_out != 2'd2) fail_timeout(name);
  endtask

  typedef struct {
    logic [3:0]  sw;
    logic [15:0] exp_digits;
    int          exp_cnt;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{sw: 4'b0001, exp_digits: 16'h0123, exp_cnt: 1};
    vecs[1] = '{sw: 4'b0010, exp_digits: 16'h0321, exp_cnt: 2};
    vecs[2] = '{sw: 4'b0000, exp_digits: 16'h0321, exp_cnt: 2};
    vecs[3] = '{sw: 4'b0100, exp_digits: 16'h3012, exp_cnt: 3};
    vecs[4] = '{sw: 4'b0111, exp_digits: 16'h2103, exp_cnt: 4};

    model_reset();

    // Reset state and idle hold
    do_reset();
    repeat (100) cycle(4'd0, 1'b1);
    check("idle_hex3", {25'd0, hex3}, 32'h30);
    check("idle_hex2", {25'd0, hex2}, 32'h24);
    check("idle_hex1", {25'd0, hex1}, 32'h79);
    check("idle_hex0", {25'd0, hex0}, 32'h40);
    check("idle_cnt", {24'd0, step_cnt}, 32'd0);
    check("idle_state", {30'd0, state_out}, 32'd0);

    // Manual steps, key held 20 cycles each
    for (int v = 0; v < 5; v++) begin
      repeat (20) cycle(vecs[v].sw, 1'b0);
      repeat (10) cycle(vecs[v].sw, 1'b1);
      check_digits("tbl_digits", vecs[v].exp_digits);
      check("tbl_cnt", {24'd0, step_cnt}, vecs[v].exp_cnt);
    end

    // Auto PAIRSWAP: tick spacing and alternation
    begin
      int last, napply, cyc;
      do_reset();
      last = -1; napply = 0; cyc = 0;
      while (napply < 4 && cyc < 200) begin
        cycle(4'b1100, 1'b1);
        cyc++;
        if (state_out == 2'd2) begin
          if (last >= 0) check("tick_spacing", cyc - last, 32'd5);
          last = cyc;
          napply++;
          cycle(4'b1100, 1'b1);
          cyc++;
          check_digits("auto_alt", (napply % 2 == 1) ? 16'h2301 : 16'h3210);
        end
      end
      if (napply < 4) fail_timeout("auto_applies");
      check("auto_cnt", {24'd0, step_cnt}, 32'd4);
    end

    // Priority with SW0+SW1, drop run enable during APPLY
    do_reset();
    wait_apply(4'b1011, "rev_apply");
    cycle(4'b0011, 1'b1);
    repeat (3) cycle(4'b0011, 1'b1);
    check("drop_cnt", {24'd0, step_cnt}, 32'd1);
    check_digits("drop_digits", 16'h0123);
    repeat (20) cycle(4'b0011, 1'b1);
    check("drop_state", {30'd0, state_out}, 32'd0);
    check("drop_cnt_after", {24'd0, step_cnt}, 32'd1);

    // Counter wrap and reset inside APPLY
    begin
      int c, nsteps;
      bit seen;
      do_reset();
      c = 0; nsteps = 0; seen = 0;
      while (!(seen && step_cnt == 8'd0) && c < 1600) begin
        cycle(4'b1001, 1'b1);
        c++;
        if (step_cnt != 8'd0) seen = 1;
        if (state_out == 2'd2) nsteps++;
      end
      if (!(seen && step_cnt == 8'd0)) fail_timeout("wrap");
      check("wrap_steps", nsteps, 32'd256);
      check("wrap_cnt", {24'd0, step_cnt}, 32'd0);
      wait_apply(4'b1001, "apply_257");
      cycle(4'b1001, 1'b1);
      wait_apply(4'b1001, "apply_258");
      check_digits("pre_reset_digits", 16'h0123);
      #2 rst_n = 1'b0;
      #1;
      check_digits("async_rst_digits", INIT);
      check("async_rst_cnt", {24'd0, step_cnt}, 32'd0);
      check("async_rst_state", {30'd0, state_out}, 32'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
    end

    // Random stimulus against the model
    begin
      logic [3:0] s;
      logic       k;
      int         hold;
      s = 4'd0; k = 1'b1; hold = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 29) == 0) s = 4'($urandom_range(0, 15));
        if (hold == 0) begin
          k    = ~k;
          hold = $urandom_range(1, 12);
        end else begin
          hold--;
        end
        cycle(s, k);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
